// File: rtl/dram_bist.sv
// dram_bist: writes a selectable pattern to every DRAM page through the controller FIFOs, then
// reads each page back and checks it. Define DRAM_BIST_FIRST_ERR_EN to build first-failure capture.
module dram_bist #(
    parameter int LOG_DRAM_SIZE   = 10,
    parameter int PAGE_LEN        = 32,
    parameter int LOG_ADDR_SIZE   = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
    parameter int LOG_REQ_SIZE    = 1 + LOG_ADDR_SIZE,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     frq_write_en,
    output logic [LOG_REQ_SIZE-1:0]  frq_write_data,
    input  logic                     frq_full,
    output logic                     fout_write_en,
    output logic [PAGE_LEN-1:0]      fout_write_data,
    input  logic                     fout_full,
    output logic                     fin_read_en,
    input  logic [PAGE_LEN-1:0]      fin_read_data,
    input  logic                     fin_empty,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic [LOG_ADDR_SIZE-1:0] first_err_addr,
    output logic [PAGE_LEN-1:0]      first_err_data
);

    localparam int                     OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]       MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [LOG_ADDR_SIZE-1:0] LAST_PAGE = '1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    function automatic logic [PAGE_LEN-1:0] pattern(input logic [1:0] m,
                                                    input logic [LOG_ADDR_SIZE-1:0] a);
        logic [PAGE_LEN-1:0] p0;
        logic [PAGE_LEN-1:0] one;
        p0  = PAGE_LEN'(a);
        one = PAGE_LEN'(1);
        case (m)
            2'd0:    return p0;
            2'd1:    return ~p0;
            2'd2:    return one << (int'(a) % PAGE_LEN);
            default: return a[0] ? {PAGE_LEN/2{2'b10}} : {PAGE_LEN/2{2'b01}};
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [LOG_ADDR_SIZE-1:0] wa_q, wa_d;
    logic [LOG_ADDR_SIZE:0]   ra_q, ra_d;
    logic [LOG_ADDR_SIZE-1:0] ca_q, ca_d;
    logic [OUT_W-1:0]         outst_q, outst_d;
    logic                     error_q, error_d;
    logic [ERR_CNT_W-1:0]     err_count_q, err_count_d;

    logic wr_issue;
    logic rd_issue;
    logic pop;
    logic mismatch;
    logic start_accept;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        mode_d       = mode_q;
        wa_d         = wa_q;
        ra_d         = ra_q;
        ca_d         = ca_q;
        outst_d      = outst_q;
        error_d      = error_q;
        err_count_d  = err_count_q;

        start_accept = ((state_q == IDLE) || (state_q == DONE)) && start;
        wr_issue     = (state_q == WRITE) && !frq_full && !fout_full;
        rd_issue     = (state_q == READ) && !ra_q[LOG_ADDR_SIZE] && (outst_q < MAX_OUT) && !frq_full;
        pop          = (state_q == READ) && !fin_empty && (outst_q != '0);
        mismatch     = pop && (fin_read_data != pattern(mode_q, ca_q));

        case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    state_d     = WRITE;
                    mode_d      = mode;
                    wa_d        = '0;
                    ra_d        = '0;
                    ca_d        = '0;
                    outst_d     = '0;
                    error_d     = 1'b0;
                    err_count_d = '0;
                end
            end
            WRITE: begin
                if (wr_issue) begin
                    wa_d = wa_q + LOG_ADDR_SIZE'(1);
                    if (wa_q == LAST_PAGE) state_d = READ;
                end
            end
            READ: begin
                if (rd_issue) ra_d = ra_q + (LOG_ADDR_SIZE + 1)'(1);
                if (rd_issue && !pop)      outst_d = outst_q + OUT_W'(1);
                else if (!rd_issue && pop) outst_d = outst_q - OUT_W'(1);
                if (pop) begin
                    ca_d = ca_q + LOG_ADDR_SIZE'(1);
                    if (ca_q == LAST_PAGE) state_d = DONE;
                end
                if (mismatch) begin
                    error_d = 1'b1;
                    if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            wa_q        <= '0;
            ra_q        <= '0;
            ca_q        <= '0;
            outst_q     <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wa_q        <= wa_d;
            ra_q        <= ra_d;
            ca_q        <= ca_d;
            outst_q     <= outst_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    // The request FIFO is shared: WRITE pushes write requests, READ pushes read requests.
    assign frq_write_en    = wr_issue || rd_issue;
    assign frq_write_data  = (state_q == WRITE) ? LOG_REQ_SIZE'({wa_q, 1'b1})
                                                : LOG_REQ_SIZE'({ra_q[LOG_ADDR_SIZE-1:0], 1'b0});
    assign fout_write_en   = wr_issue;
    assign fout_write_data = pattern(mode_q, wa_q);
    assign fin_read_en     = pop;
    assign busy            = (state_q == WRITE) || (state_q == READ);
    assign done            = (state_q == DONE);
    assign error           = error_q;
    assign err_count       = err_count_q;

`ifdef DRAM_BIST_FIRST_ERR_EN
    logic [LOG_ADDR_SIZE-1:0] first_err_addr_q, first_err_addr_d;
    logic [PAGE_LEN-1:0]      first_err_data_q, first_err_data_d;

    always_comb begin
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        if (start_accept) begin
            first_err_addr_d = '0;
            first_err_data_d = '0;
        end else if (mismatch && !error_q) begin
            first_err_addr_d = ca_q;
            first_err_data_d = fin_read_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_dram_bist.sv
// Bench for dram_bist: FIFO/memory model with a write/read scoreboard, a table of run scenarios,
// and hand-written reset and saturation sequences.
module tb_dram_bist;

    localparam int PAGES = 32;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        int          fault_addr;
        logic [31:0] fault_mask;
        bit          corrupt_all;
        bit          bp_frq;
        bit          bp_fout;
        int          hold;
        bit          poke;
        logic        exp_error;
        int          exp_cnt;
        logic [4:0]  exp_faddr;
        logic [31:0] exp_fdata;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        frq_full = 1'b0;
    logic        fout_full = 1'b0;
    logic        fin_empty = 1'b1;
    logic [31:0] fin_read_data = '0;

    logic        frq_write_en, fout_write_en, fin_read_en, busy, done, error;
    logic [5:0]  frq_write_data;
    logic [31:0] fout_write_data, first_err_data;
    logic [7:0]  err_count;
    logic [4:0]  first_err_addr;

    logic        frq_write_en_s, fout_write_en_s, fin_read_en_s, busy_s, done_s, error_s;
    logic [5:0]  frq_write_data_s;
    logic [31:0] fout_write_data_s, first_err_data_s;
    logic [3:0]  err_count_s;
    logic [4:0]  first_err_addr_s;

    dram_bist dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .frq_write_en(frq_write_en), .frq_write_data(frq_write_data), .frq_full(frq_full),
        .fout_write_en(fout_write_en), .fout_write_data(fout_write_data), .fout_full(fout_full),
        .fin_read_en(fin_read_en), .fin_read_data(fin_read_data), .fin_empty(fin_empty),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    // Narrow-counter copy runs in lockstep on the same stimulus to exercise saturation.
    dram_bist #(.ERR_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .frq_write_en(frq_write_en_s), .frq_write_data(frq_write_data_s), .frq_full(frq_full),
        .fout_write_en(fout_write_en_s), .fout_write_data(fout_write_data_s), .fout_full(fout_full),
        .fin_read_en(fin_read_en_s), .fin_read_data(fin_read_data), .fin_empty(fin_empty),
        .busy(busy_s), .done(done_s), .error(error_s), .err_count(err_count_s),
        .first_err_addr(first_err_addr_s), .first_err_data(first_err_data_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_pat(input logic [1:0] m, input int a);
        case (m)
            2'd0:    return 32'(a);
            2'd1:    return ~32'(a);
            2'd2:    return 32'h1 << (a % 32);
            default: return (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    // Memory and FIFO model state
    vec_t        cfg;
    logic [31:0] mem [PAGES];
    logic [31:0] fin_q [$];
    wr_t         exp_wr [$];
    logic [4:0]  exp_rd [$];
    wr_t         e_wr;
    logic [4:0]  e_rd;
    logic [31:0] resp;
    int          wr_seen, rd_seen, pop_seen, viol, cyc;
    int          fout_left, hold_left, rd_at_release;
    bit          fout_stalled;
    bit          p_wr, p_rd, p_pop, p_poke;
    logic [4:0]  p_waddr, p_raddr;
    logic [31:0] p_wdata;

    // Each negedge: commit what the DUT did at the previous posedge, drive new inputs,
    // then sample what it will do at the next posedge.
    always @(negedge clk) begin
        if (p_wr) mem[p_waddr] = p_wdata;
        if (p_rd) begin
            resp = mem[p_raddr];
            if (cfg.corrupt_all) resp = resp ^ 32'h1;
            if (int'(p_raddr) == cfg.fault_addr) resp = resp ^ cfg.fault_mask;
            fin_q.push_back(resp);
        end
        if (p_pop && fin_q.size() > 0) void'(fin_q.pop_front());
        if (p_poke) start = 1'b0;
        p_wr = 1'b0; p_rd = 1'b0; p_pop = 1'b0; p_poke = 1'b0;
        cyc++;

        frq_full = cfg.bp_frq ? cyc[0] : 1'b0;
        if (cfg.bp_fout && !fout_stalled && wr_seen >= 10) begin
            fout_stalled = 1'b1;
            fout_left    = 10;
        end
        fout_full = (fout_left > 0);
        if (fout_left > 0) fout_left--;
        fin_empty     = (fin_q.size() == 0) || (hold_left > 0);
        fin_read_data = (fin_q.size() > 0) ? fin_q[0] : 32'hDEAD_BEEF;
        if (hold_left > 0 && rd_seen > 0) begin
            hold_left--;
            if (hold_left == 0) rd_at_release = rd_seen;
        end

        #1;
        if (!rst) begin
            if (frq_write_en) begin
                if (frq_full) viol++;
                if (frq_write_data[0]) begin
                    p_wr = 1'b1; p_waddr = frq_write_data[5:1]; p_wdata = fout_write_data;
                    wr_seen++;
                    if (!fout_write_en) viol++;
                    if (exp_wr.size() == 0) check("wr_count", 64'(wr_seen), 64'(PAGES));
                    else begin
                        e_wr = exp_wr.pop_front();
                        check("wr_addr", 64'(p_waddr), 64'(e_wr.addr));
                        check("wr_data", 64'(p_wdata), 64'(e_wr.data));
                    end
                end else begin
                    p_rd = 1'b1; p_raddr = frq_write_data[5:1];
                    rd_seen++;
                    if (exp_rd.size() == 0) check("rd_count", 64'(rd_seen), 64'(PAGES));
                    else begin
                        e_rd = exp_rd.pop_front();
                        check("rd_addr", 64'(p_raddr), 64'(e_rd));
                    end
                end
            end
            if (fout_write_en && (fout_full || !frq_write_en || !frq_write_data[0])) viol++;
            if (fin_read_en) begin
                if (fin_empty) viol++;
                p_pop = 1'b1;
                pop_seen++;
                if (cfg.poke && pop_seen == PAGES) begin
                    start  = 1'b1;
                    p_poke = 1'b1;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_cnt"},   64'(err_count), 64'(0));
        check({tag, "_en"},    64'({frq_write_en, fout_write_en, fin_read_en}), 64'(0));
        check({tag, "_faddr"}, 64'(first_err_addr), 64'(0));
        check({tag, "_fdata"}, 64'(first_err_data), 64'(0));
    endtask

    task automatic arm(input vec_t v);
        cfg = v;
        wr_seen = 0; rd_seen = 0; pop_seen = 0; viol = 0;
        fout_left = 0; fout_stalled = 1'b0; hold_left = v.hold; rd_at_release = -1;
        exp_wr.delete(); exp_rd.delete();
        for (int a = 0; a < PAGES; a++) begin
            wr_t w;
            w.addr = 5'(a);
            w.data = model_pat(v.mode, a);
            exp_wr.push_back(w);
            exp_rd.push_back(5'(a));
        end
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk); #2;
        start = 1'b1; mode = m;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        logic [4:0]  ef_addr;
        logic [31:0] ef_data;
        arm(v);
        pulse_start(v.mode);
        check({v.name, "_busy_rise"}, 64'(busy), 64'(1));
        if (!v.bp_frq) check({v.name, "_first_wr"}, 64'(wr_seen), 64'(1));
        if (v.bp_frq) begin
            repeat (5) @(negedge clk);
            pulse_start(~v.mode);
        end
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({v.name, "_done_seen"}, 64'(done), 64'(1));
        repeat (2) @(negedge clk);
        #2;
`ifdef DRAM_BIST_FIRST_ERR_EN
        ef_addr = v.exp_faddr;
        ef_data = v.exp_fdata;
`else
        ef_addr = '0;
        ef_data = '0;
`endif
        check({v.name, "_done_held"},  64'(done), 64'(1));
        check({v.name, "_busy_low"},   64'(busy), 64'(0));
        check({v.name, "_error"},      64'(error), 64'(v.exp_error));
        check({v.name, "_err_count"},  64'(err_count), 64'(v.exp_cnt > 255 ? 255 : v.exp_cnt));
        check({v.name, "_first_addr"}, 64'(first_err_addr), 64'(ef_addr));
        check({v.name, "_first_data"}, 64'(first_err_data), 64'(ef_data));
        check({v.name, "_sat_error"},  64'(error_s), 64'(v.exp_error));
        check({v.name, "_sat_count"},  64'(err_count_s), 64'(v.exp_cnt > 15 ? 15 : v.exp_cnt));
        check({v.name, "_writes"},     64'(wr_seen), 64'(PAGES));
        check({v.name, "_reads"},      64'(rd_seen), 64'(PAGES));
        check({v.name, "_pops"},       64'(pop_seen), 64'(PAGES));
        check({v.name, "_protocol"},   64'(viol), 64'(0));
        if (v.hold > 0) check({v.name, "_outst_limit"}, 64'(rd_at_release), 64'(4));
    endtask

    initial begin
        vec_t vecs[6];
        int   c;
        vecs[0] = '{name:"clean_m0", mode:2'd0, fault_addr:-1, fault_mask:32'h0, corrupt_all:0,
                    bp_frq:0, bp_fout:0, hold:0, poke:1, exp_error:0, exp_cnt:0,
                    exp_faddr:5'd0, exp_fdata:32'h0};
        vecs[1] = '{name:"fault_m2", mode:2'd2, fault_addr:5, fault_mask:32'h8, corrupt_all:0,
                    bp_frq:0, bp_fout:0, hold:0, poke:0, exp_error:1, exp_cnt:1,
                    exp_faddr:5'd5, exp_fdata:32'h28};
        vecs[2] = '{name:"backpressure", mode:2'd0, fault_addr:-1, fault_mask:32'h0, corrupt_all:0,
                    bp_frq:1, bp_fout:1, hold:0, poke:0, exp_error:0, exp_cnt:0,
                    exp_faddr:5'd0, exp_fdata:32'h0};
        vecs[3] = '{name:"withhold", mode:2'd2, fault_addr:-1, fault_mask:32'h0, corrupt_all:0,
                    bp_frq:0, bp_fout:0, hold:20, poke:0, exp_error:0, exp_cnt:0,
                    exp_faddr:5'd0, exp_fdata:32'h0};
        vecs[4] = '{name:"saturate_m1", mode:2'd1, fault_addr:-1, fault_mask:32'h0, corrupt_all:1,
                    bp_frq:0, bp_fout:0, hold:0, poke:0, exp_error:1, exp_cnt:32,
                    exp_faddr:5'd0, exp_fdata:32'hFFFF_FFFE};
        vecs[5] = '{name:"after_reset_m3", mode:2'd3, fault_addr:-1, fault_mask:32'h0, corrupt_all:0,
                    bp_frq:0, bp_fout:0, hold:0, poke:0, exp_error:0, exp_cnt:0,
                    exp_faddr:5'd0, exp_fdata:32'h0};

        arm(vecs[0]);
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        check_all_zero("idle");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort a run partway through the read sweep with an asynchronous reset.
        arm(vecs[0]);
        pulse_start(2'd0);
        c = 0;
        while (rd_seen < 6 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("abort_reached_read", 64'(rd_seen >= 6), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort");
        fin_q.delete();
        p_wr = 1'b0; p_rd = 1'b0; p_pop = 1'b0; p_poke = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        run_vec(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_bist.md
# dram_bist

Parametrised built-in self-test engine for the DRAM controller's FIFO interface. It takes a one-cycle start command, writes a selectable data pattern to every page, and reads every page back. Read-back keeps up to a configurable number of read requests in flight and checks each returned page against the pattern. Results are reported as a sticky error flag, a saturating error count and optional first-failure capture. It sits between the system control logic and the controller's request, write-data and read-data FIFOs.

## Interface
- LOG_DRAM_SIZE, 10, log2 of DRAM size in bits
- PAGE_LEN, 32, page (data word) width in bits
- LOG_ADDR_SIZE, LOG_DRAM_SIZE - $clog2(PAGE_LEN), page address width
- LOG_REQ_SIZE, 1 + LOG_ADDR_SIZE, request word width
- MAX_OUTSTANDING, 4, maximum read requests issued but not yet returned (1..255)
- ERR_CNT_W, 8, error counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that launches a run; ignored while busy
- mode  in  2  pattern select, sampled on start
- frq_write_en  out  1  request FIFO push
- frq_write_data  out  LOG_REQ_SIZE  request word {page_addr, we}; we=1 for write, we=0 for read
- frq_full  in  1  request FIFO full
- fout_write_en  out  1  write-data FIFO push
- fout_write_data  out  PAGE_LEN  write data
- fout_full  in  1  write-data FIFO full
- fin_read_en  out  1  read-data FIFO pop
- fin_read_data  in  PAGE_LEN  read data, first-word-fall-through
- fin_empty  in  1  read-data FIFO empty
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- error  out  1  sticky mismatch flag
- err_count  out  ERR_CNT_W  mismatching pages, saturating
- first_err_addr  out  LOG_ADDR_SIZE  page address of first mismatch
- first_err_data  out  PAGE_LEN  data read at first mismatch

## Operation
- Pattern P(a) for page a, with the mode latched at start:
  - 0: a zero-extended to PAGE_LEN
  - 1: ~P0(a), the bitwise inverse of the mode-0 word
  - 2: 1 << (a mod PAGE_LEN)
  - 3: a[0] ? {PAGE_LEN/2{2'b10}} : {PAGE_LEN/2{2'b01}}
- States: IDLE, WRITE, READ, DONE.
- IDLE / DONE, on start: clear done, error, err_count and first-error registers; zero the address counters; go to WRITE.
- WRITE:
  - A write is issued on any cycle with !frq_full && !fout_full.
  - Issuing pushes frq = {wa, 1'b1} and fout = P(wa) in the same cycle, then increments wa.
  - After page 2^LOG_ADDR_SIZE-1 is issued, wa wraps to 0 and the state goes to READ.
- READ, issue side:
  - A read is issued when ra < 2^LOG_ADDR_SIZE, outst < MAX_OUTSTANDING and !frq_full.
  - Issuing pushes {ra, 1'b0}.
  - ra is one bit wider than the address, so the end of the issue sweep is detectable.
- READ, check side:
  - fin_read_en = READ && !fin_empty && outst != 0.
  - On a pop, compare fin_read_data with P(ca). On mismatch: set error, increment err_count (saturating at all-ones), and capture the first error.
  - Increment ca after each pop.
- outst handling: +1 on issue, -1 on pop, unchanged when both happen in the same cycle.
- Data in fin while outst == 0 is not popped and not checked.
- READ exits to DONE on the pop of the last page: clear busy, set done.
- Enables are combinational from state, counters and the full/empty inputs. No push ever occurs while the target FIFO is full; no pop occurs while fin is empty.
- frq_write_data and fout_write_data are don't-care when their enables are low.

## Timing
- Reset values: every output is 0, the state is IDLE and all counters are 0.
- busy rises the cycle after start.
- Throughput: with no backpressure, one write per cycle and one read per cycle.
- The first write request appears one cycle after start.
- done and the final error/err_count values are valid in the cycle after the last pop.
- start asserted in the same cycle that done rises is ignored.
- Reset mid-run aborts immediately. Responses still in flight in the external FIFOs are not drained; the system resets those FIFOs together with this block.

## Configuration
- DRAM_BIST_FIRST_ERR_EN:
  - Defined: first_err_addr and first_err_data load on the first mismatch of a run and hold until the next start.
  - Undefined: the capture registers are not built and both outputs are constant 0.
- error and err_count are unaffected by the macro.

## Test plan
All scenarios use default parameters (32 pages).
- Clean run: mode 0, ideal memory with 1-cycle response latency -> 32 writes with data 0..31, 32 reads, done=1, error=0, err_count=0.
- Injected fault: mode 2, memory flips bit 3 on page 5 -> error=1, err_count=1, first_err_addr=5, first_err_data=0x28 (macro defined) or 0 (macro undefined).
- Backpressure: frq_full high on alternate cycles, fout_full high for 10 cycles mid-WRITE -> no push while full; exactly 32 writes and 32 reads; clean result.
- Outstanding limit: memory withholds responses for 20 cycles -> exactly 4 reads issued, then the issue side stalls; completes cleanly after release.
- Saturation: ERR_CNT_W=4, mode 1, every page corrupted -> err_count=15 and error=1.
- Reset mid-READ, then a new start with mode 3 -> all outputs 0 after reset; the second run completes with error=0.
